trace_trigger: RTL and testbench

- Trace-port matching stage fed by the trace register block.
- Each cycle, shifts raw TPIU lane data into a capture buffer and detects the TPIU full-sync word.
- Compares the buffer against up to 8 masked patterns; reports matches, counts them and drives the trace trigger output.
- Runs entirely in the trace clock domain. Configuration inputs arrive already synchronised to trace_clk.

---
 rtl/trace_trigger_pkg.sv | 18 +
 rtl/trace_trigger_if.sv | 37 +++
 rtl/trace_match_rule.sv | 59 +++++
 rtl/trace_trigger.sv | 109 ++++++++++
 tb/tb_trace_trigger.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_trigger_pkg.sv
// Shared constants for the trace trigger block.
//   TPIU_SYNC     : TPIU full-sync word that must sit in the top 32 buffer bits
//   trace_width_e : encodings of the active lane count
//   CNT_W/CNT_MAX : width and saturation value of the per-rule event counters
package trace_trigger_pkg;

  localparam logic [31:0] TPIU_SYNC = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    TW_1 = 3'd1,
    TW_2 = 3'd2,
    TW_4 = 3'd4
  } trace_width_e;

  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/trace_trigger_if.sv
// Bus bundle between the trace register block / capture logic and the trace
// trigger. Signal names keep the register-block naming (I_* config into the
// trigger, O_* status out of it).
//   master : register block side (drives lane data and configuration)
//   slave  : trace_trigger side (drives match status, counts and trigger)
interface trace_trigger_if #(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
);
  logic [3:0]                           trace_data;
  logic [2:0]                           I_trace_width;
  logic                                 I_trace_reset_sync;
  logic [pMATCH_RULES-1:0]              I_pattern_enable;
  logic                                 I_trig_toggle;
  logic                                 I_trace_trig_enable;
  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_patterns;
  logic [pMATCH_RULES*pBUFFER_SIZE-1:0] I_masks;
  logic [pMATCH_RULES-1:0]              O_matching_pattern;
  logic [pBUFFER_SIZE-1:0]              O_matching_buffer;
  logic                                 O_synchronized;
  logic [8*pMATCH_RULES-1:0]            O_trace_counts;
  logic                                 O_trace_trig;

  modport master (
    output trace_data, I_trace_width, I_trace_reset_sync, I_pattern_enable,
           I_trig_toggle, I_trace_trig_enable, I_patterns, I_masks,
    input  O_matching_pattern, O_matching_buffer, O_synchronized,
           O_trace_counts, O_trace_trig
  );

  modport slave (
    input  trace_data, I_trace_width, I_trace_reset_sync, I_pattern_enable,
           I_trig_toggle, I_trace_trig_enable, I_patterns, I_masks,
    output O_matching_pattern, O_matching_buffer, O_synchronized,
           O_trace_counts, O_trace_trig
  );
endinterface

// File: rtl/trace_match_rule.sv
// One pattern/mask rule: masked compare of the capture buffer, rising-edge
// detect of the hit, and a saturating event counter.
//   clk, rst  : trace clock, asynchronous active-high reset
//   enable    : rule enable
//   synced    : sync word has been seen; no hits before that
//   clear     : level clear of the counter (wins over increment)
//   buffer    : registered capture buffer
//   pattern   : rule pattern; mask bit 1 = bit compared
//   hit       : combinational match this cycle
//   event_o   : hit that was not present last cycle
//   count     : saturating event count
module trace_match_rule
  import trace_trigger_pkg::*;
#(
  parameter int pBUFFER_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    synced,
  input  logic                    clear,
  input  logic [pBUFFER_SIZE-1:0] buffer,
  input  logic [pBUFFER_SIZE-1:0] pattern,
  input  logic [pBUFFER_SIZE-1:0] mask,
  output logic                    hit,
  output logic                    event_o,
  output logic [CNT_W-1:0]        count
);

  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    hit     = enable & synced & (((buffer ^ pattern) & mask) == '0);
    // Only the first cycle of a hit is an event, so a buffer that stays
    // matching is counted once.
    event_o = hit & ~match_q;
    match_d = hit;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (event_o && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/trace_trigger.sv
// Trace-port matching stage. Shifts TPIU lane data into a capture buffer
// (newest bits at the MSB), detects the TPIU full-sync word, compares the
// buffer against pMATCH_RULES masked patterns and drives the trace trigger.
//   trace_clk : trace capture clock
//   reset_i   : asynchronous active-high reset
//   bus       : lane data, configuration in; match status, counts, trigger out
module trace_trigger
  import trace_trigger_pkg::*;
#(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
) (
  input  logic           trace_clk,
  input  logic           reset_i,
  trace_trigger_if.slave bus
);

  logic [pBUFFER_SIZE-1:0]       buffer_q, buffer_d;
  logic                          synced_q, synced_d;
  logic [pMATCH_RULES-1:0]       match_pattern_q, match_pattern_d;
  logic [pBUFFER_SIZE-1:0]       match_buffer_q, match_buffer_d;
  logic                          trig_q, trig_d;
  logic                          toggle_mode_q, toggle_mode_d;
  logic [pMATCH_RULES-1:0]       hit;
  logic [pMATCH_RULES-1:0]       evt;
  logic [CNT_W*pMATCH_RULES-1:0] counts;
  logic                          any_event;

  always_comb begin
    // Unrecognised width codes fall back to all four lanes.
    buffer_d = {bus.trace_data, buffer_q[pBUFFER_SIZE-1:4]};
    if (bus.I_trace_width == TW_1) begin
      buffer_d = {bus.trace_data[0], buffer_q[pBUFFER_SIZE-1:1]};
    end else if (bus.I_trace_width == TW_2) begin
      buffer_d = {bus.trace_data[1:0], buffer_q[pBUFFER_SIZE-1:2]};
    end

    // reset_sync wins over a sync word seen on the same edge.
    synced_d = synced_q;
    if (bus.I_trace_reset_sync) begin
      synced_d = 1'b0;
    end else if (buffer_q[pBUFFER_SIZE-1 -: 32] == TPIU_SYNC) begin
      synced_d = 1'b1;
    end

    // Snapshot every rule currently hitting, not just the newly hitting ones.
    match_pattern_d = match_pattern_q;
    match_buffer_d  = match_buffer_q;
    if (|evt) begin
      match_pattern_d = hit;
      match_buffer_d  = buffer_q;
    end

    any_event     = (|evt) & bus.I_trace_trig_enable;
    toggle_mode_d = bus.I_trig_toggle;
    // A mode change parks the trigger low so the capture logic never sees a
    // stale toggle level reinterpreted as a pulse (or vice versa).
    if (bus.I_trig_toggle != toggle_mode_q) begin
      trig_d = 1'b0;
    end else if (toggle_mode_q) begin
      trig_d = trig_q ^ any_event;
    end else begin
      trig_d = any_event;
    end
  end

  always_ff @(posedge trace_clk or posedge reset_i) begin
    if (reset_i) begin
      buffer_q        <= '0;
      synced_q        <= 1'b0;
      match_pattern_q <= '0;
      match_buffer_q  <= '0;
      trig_q          <= 1'b0;
      toggle_mode_q   <= 1'b0;
    end else begin
      buffer_q        <= buffer_d;
      synced_q        <= synced_d;
      match_pattern_q <= match_pattern_d;
      match_buffer_q  <= match_buffer_d;
      trig_q          <= trig_d;
      toggle_mode_q   <= toggle_mode_d;
    end
  end

  for (genvar gi = 0; gi < pMATCH_RULES; gi++) begin : g_rule
    trace_match_rule #(
      .pBUFFER_SIZE(pBUFFER_SIZE)
    ) u_rule (
      .clk     (trace_clk),
      .rst     (reset_i),
      .enable  (bus.I_pattern_enable[gi]),
      .synced  (synced_q),
      .clear   (bus.I_trace_reset_sync),
      .buffer  (buffer_q),
      .pattern (bus.I_patterns[gi*pBUFFER_SIZE +: pBUFFER_SIZE]),
      .mask    (bus.I_masks[gi*pBUFFER_SIZE +: pBUFFER_SIZE]),
      .hit     (hit[gi]),
      .event_o (evt[gi]),
      .count   (counts[gi*CNT_W +: CNT_W])
    );
  end

  assign bus.O_matching_pattern = match_pattern_q;
  assign bus.O_matching_buffer  = match_buffer_q;
  assign bus.O_synchronized     = synced_q;
  assign bus.O_trace_counts     = counts;
  assign bus.O_trace_trig       = trig_q;

endmodule

// File: tb/tb_trace_trigger.sv
module tb_trace_trigger;
  import trace_trigger_pkg::*;

  localparam int BW = 64;
  localparam int NR = 8;

  logic trace_clk = 1'b0;
  logic reset_i   = 1'b1;

  always #5 trace_clk = ~trace_clk;

  trace_trigger_if #(.pBUFFER_SIZE(BW), .pMATCH_RULES(NR)) bus ();

  trace_trigger #(.pBUFFER_SIZE(BW), .pMATCH_RULES(NR)) dut (
    .trace_clk (trace_clk),
    .reset_i   (reset_i),
    .bus       (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          trig_highs = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp;

  // One clock edge; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge trace_clk);
    #1;
    if (bus.O_trace_trig === 1'b1) trig_highs++;
  endtask

  // Shift a 32-bit word in at width 4, least significant nibble first.
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 8; k++) begin
      bus.trace_data = w[4*k +: 4];
      tick();
    end
  endtask

  task automatic do_sync();
    push_word(TPIU_SYNC);
    bus.trace_data = 4'h0;
    tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (5) exp_q.push_back(64'h0);
    repeat (3) tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_synchronized) !== exp) begin n_err++; $display("FAIL rst_sync: got %h want %h", bus.O_synchronized, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_trig) !== exp) begin n_err++; $display("FAIL rst_trig: got %h want %h", bus.O_trace_trig, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL rst_pattern: got %h want %h", bus.O_matching_pattern, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL rst_counts: got %h want %h", bus.O_trace_counts, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_matching_buffer !== exp) begin n_err++; $display("FAIL rst_buffer: got %h want %h", bus.O_matching_buffer, exp); end
    #3 reset_i = 1'b0;
    tick();
    $display("reset: checked");
  endtask

  task automatic test_sync();
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd0);
    push_word(32'h7FFF_FFFF);
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_synchronized) !== exp) begin n_err++; $display("FAIL sync_early: got %h want %h", bus.O_synchronized, exp); end
    bus.trace_data = 4'h0;
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_synchronized) !== exp) begin n_err++; $display("FAIL sync_set: got %h want %h", bus.O_synchronized, exp); end
    bus.I_trace_reset_sync = 1'b1;
    tick();
    bus.I_trace_reset_sync = 1'b0;
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_synchronized) !== exp) begin n_err++; $display("FAIL sync_clear: got %h want %h", bus.O_synchronized, exp); end
    // Sync word present on the same edge as reset_sync: reset_sync wins.
    exp_q.push_back(64'd0);
    push_word(32'h7FFF_FFFF);
    bus.trace_data = 4'h0;
    bus.I_trace_reset_sync = 1'b1;
    tick();
    bus.I_trace_reset_sync = 1'b0;
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_synchronized) !== exp) begin n_err++; $display("FAIL sync_vs_reset_sync: got %h want %h", bus.O_synchronized, exp); end
    do_sync();
    $display("sync: set, cleared, priority checked");
  endtask

  task automatic test_pulse_match();
    bus.I_patterns[2*BW +: BW] = 64'h0000_0000_DEAD_BEEF;
    bus.I_masks[2*BW +: BW]    = 64'h0000_0000_FFFF_FFFF;
    bus.I_pattern_enable       = 8'h04;
    trig_highs = 0;
    exp_q.push_back(64'h00);
    exp_q.push_back(64'h04);
    exp_q.push_back(64'h0000_0000_DEAD_BEEF);
    exp_q.push_back(64'h0000_0000_0001_0000);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);
    push_word(32'hDEAD_BEEF);
    push_word(32'h0);
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL pulse_latency: got %h want %h", bus.O_matching_pattern, exp); end
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL pulse_pattern: got %h want %h", bus.O_matching_pattern, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_matching_buffer !== exp) begin n_err++; $display("FAIL pulse_snapshot: got %h want %h", bus.O_matching_buffer, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL pulse_count: got %h want %h", bus.O_trace_counts, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_trig) !== exp) begin n_err++; $display("FAIL pulse_trig_hi: got %h want %h", bus.O_trace_trig, exp); end
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_trig) !== exp) begin n_err++; $display("FAIL pulse_trig_lo: got %h want %h", bus.O_trace_trig, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(trig_highs) !== exp) begin n_err++; $display("FAIL pulse_width: got %0d want %0d", trig_highs, exp); end
    $display("pulse match: rule 2 event checked");
  endtask

  task automatic test_toggle();
    bus.I_trig_toggle = 1'b1;
    exp_q.push_back(64'd0);
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_trig) !== exp) begin n_err++; $display("FAIL toggle_mode_change: got %h want %h", bus.O_trace_trig, exp); end
    for (int e = 0; e < 3; e++) begin
      exp_q.push_back((e % 2 == 0) ? 64'd1 : 64'd0);
      exp_q.push_back(64'(2 + e));
      push_word(32'hDEAD_BEEF);
      push_word(32'h0);
      tick();
      exp = exp_q.pop_front(); n_vec++;
      if (64'(bus.O_trace_trig) !== exp) begin n_err++; $display("FAIL toggle_trig_%0d: got %h want %h", e, bus.O_trace_trig, exp); end
      exp = exp_q.pop_front(); n_vec++;
      if (64'(bus.O_trace_counts[23:16]) !== exp) begin n_err++; $display("FAIL toggle_count_%0d: got %0d want %0d", e, bus.O_trace_counts[23:16], exp); end
      $display("toggle event %0d: trig=%0d count2=%0d", e, bus.O_trace_trig, bus.O_trace_counts[23:16]);
    end
    // Flip the mode away and back to park the trigger low.
    exp_q.push_back(64'd0);
    bus.I_trig_toggle = 1'b0;
    tick();
    bus.I_trig_toggle = 1'b1;
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_trig) !== exp) begin n_err++; $display("FAIL toggle_park: got %h want %h", bus.O_trace_trig, exp); end
    bus.I_trace_trig_enable = 1'b0;
    trig_highs = 0;
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd5);
    push_word(32'hDEAD_BEEF);
    push_word(32'h0);
    tick();
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(trig_highs) !== exp) begin n_err++; $display("FAIL trig_disabled: got %0d want %0d", trig_highs, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_counts[23:16]) !== exp) begin n_err++; $display("FAIL disabled_count: got %0d want %0d", bus.O_trace_counts[23:16], exp); end
    bus.I_trace_trig_enable = 1'b1;
    bus.I_trig_toggle = 1'b0;
    tick();
  endtask

  task automatic test_static_and_saturate();
    bus.I_pattern_enable   = 8'h00;
    bus.I_trace_reset_sync = 1'b1;
    exp_q.push_back(64'h0);
    tick();
    bus.I_trace_reset_sync = 1'b0;
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL counts_clear: got %h want %h", bus.O_trace_counts, exp); end
    bus.I_patterns[0 +: BW] = 64'h0;
    bus.I_masks[0 +: BW]    = {BW{1'b1}};
    bus.I_pattern_enable    = 8'h01;
    do_sync();
    bus.I_trace_width = 3'd1;
    bus.trace_data    = 4'h0;
    trig_highs = 0;
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'h01);
    repeat (BW + 10) tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_counts[7:0]) !== exp) begin n_err++; $display("FAIL static_count: got %0d want %0d", bus.O_trace_counts[7:0], exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(trig_highs) !== exp) begin n_err++; $display("FAIL static_trig: got %0d want %0d", trig_highs, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL static_pattern: got %h want %h", bus.O_matching_pattern, exp); end
    $display("static buffer: count0=%0d triggers=%0d", bus.O_trace_counts[7:0], trig_highs);
    // Compare only the newest bit; alternating lane data gives one event per two cycles.
    bus.I_masks[0 +: BW] = 64'h8000_0000_0000_0000;
    exp_q.push_back(64'd201);
    exp_q.push_back(64'd255);
    for (int p = 0; p < 200; p++) begin
      bus.trace_data = 4'h1; tick();
      bus.trace_data = 4'h0; tick();
    end
    bus.trace_data = 4'h1; tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_counts[7:0]) !== exp) begin n_err++; $display("FAIL count_201: got %0d want %0d", bus.O_trace_counts[7:0], exp); end
    for (int p = 0; p < 100; p++) begin
      bus.trace_data = 4'h1; tick();
      bus.trace_data = 4'h0; tick();
    end
    bus.trace_data = 4'h1; tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_trace_counts[7:0]) !== exp) begin n_err++; $display("FAIL count_saturate: got %0d want %0d", bus.O_trace_counts[7:0], exp); end
    $display("saturation: count0=%0d", bus.O_trace_counts[7:0]);
  endtask

  task automatic test_two_rules();
    bus.I_trace_width  = 3'd4;
    bus.trace_data     = 4'h0;
    bus.I_pattern_enable = 8'h00;
    bus.I_trace_reset_sync = 1'b1;
    tick();
    bus.I_trace_reset_sync = 1'b0;
    bus.I_patterns[0 +: BW]    = 64'h0000_0000_CAFE_F00D;
    bus.I_masks[0 +: BW]       = 64'h0000_0000_FFFF_FFFF;
    bus.I_patterns[5*BW +: BW] = 64'h0000_0000_CAFE_F00D;
    bus.I_masks[5*BW +: BW]    = 64'h0000_0000_FFFF_FFFF;
    bus.I_pattern_enable       = 8'h21;
    // Not synchronised: the pattern passes through without any hit.
    trig_highs = 0;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h01);
    push_word(32'hCAFE_F00D);
    push_word(32'h0);
    tick(); tick();
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL unsynced_counts: got %h want %h", bus.O_trace_counts, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(trig_highs) !== exp) begin n_err++; $display("FAIL unsynced_trig: got %0d want %0d", trig_highs, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL unsynced_sticky: got %h want %h", bus.O_matching_pattern, exp); end
    do_sync();
    trig_highs = 0;
    exp_q.push_back(64'h21);
    exp_q.push_back(64'h0000_0100_0000_0001);
    exp_q.push_back(64'd1);
    push_word(32'hCAFE_F00D);
    push_word(32'h0);
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL dual_pattern: got %h want %h", bus.O_matching_pattern, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL dual_counts: got %h want %h", bus.O_trace_counts, exp); end
    tick();
    exp = exp_q.pop_front(); n_vec++;
    if (64'(trig_highs) !== exp) begin n_err++; $display("FAIL dual_trig: got %0d want %0d", trig_highs, exp); end
    $display("dual rules: pattern=%h", bus.O_matching_pattern);
  endtask

  task automatic test_async_reset();
    push_word(32'hCAFE_F00D);
    push_word(32'h0);
    // Hit is pending in the buffer; reset lands between clock edges.
    repeat (4) exp_q.push_back(64'h0);
    #2 reset_i = 1'b1;
    #1;
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_synchronized) !== exp) begin n_err++; $display("FAIL async_sync: got %h want %h", bus.O_synchronized, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(bus.O_matching_pattern) !== exp) begin n_err++; $display("FAIL async_pattern: got %h want %h", bus.O_matching_pattern, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL async_counts: got %h want %h", bus.O_trace_counts, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_matching_buffer !== exp) begin n_err++; $display("FAIL async_buffer: got %h want %h", bus.O_matching_buffer, exp); end
    tick();
    #2 reset_i = 1'b0;
    trig_highs = 0;
    exp_q.push_back(64'h0);
    exp_q.push_back(64'd0);
    tick(); tick();
    exp = exp_q.pop_front(); n_vec++;
    if (bus.O_trace_counts !== exp) begin n_err++; $display("FAIL post_reset_counts: got %h want %h", bus.O_trace_counts, exp); end
    exp = exp_q.pop_front(); n_vec++;
    if (64'(trig_highs) !== exp) begin n_err++; $display("FAIL post_reset_trig: got %0d want %0d", trig_highs, exp); end
    $display("async reset: checked");
  endtask

  initial begin
    bus.trace_data          = 4'h0;
    bus.I_trace_width       = 3'd4;
    bus.I_trace_reset_sync  = 1'b0;
    bus.I_pattern_enable    = '0;
    bus.I_trig_toggle       = 1'b0;
    bus.I_trace_trig_enable = 1'b1;
    bus.I_patterns          = '0;
    bus.I_masks             = '0;
    test_reset();
    test_sync();
    test_pulse_match();
    test_toggle();
    test_static_and_saturate();
    test_two_rules();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation timeout");
  end

endmodule
